// File: rtl/fifo_rx_apb.sv
// fifo_rx_apb: receive byte FIFO filled by the demodulator and drained by the CPU through an APB slave.
module fifo_rx_apb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  input  logic [7:0]       PADDR,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [7:0]       PWDATA,
  output logic [7:0]       PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  output logic [1:0]       mem_state,
  output logic             overflow,
  output logic             rx_irq
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (CNT_W > 8) ? CNT_W : 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  apb_state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [7:0] thresh_q, thresh_d, th_eff;
  logic [WIDTH-1:0] mem [DEPTH];
  logic acc, empty, full, err, wr, pop, flush, push, drop;
  // The access phase is the cycle whose closing edge moves the FSM from SETUP to ACCESS.
  always_comb begin
    state_d = (PSEL && !PENABLE && state_q != SETUP) ? SETUP :
              (PSEL && PENABLE && state_q == SETUP) ? ACCESS : IDLE;
    acc = state_q == SETUP && PSEL && PENABLE;
    empty = count_q == '0;
    full = count_q == CNT_W'(DEPTH);
    err = acc && (PADDR > 8'd4 || (PWRITE && (PADDR == 8'd0 || PADDR == 8'd2)) ||
                  (!PWRITE && PADDR == 8'd0 && empty));
    wr = acc && !err && PWRITE;
    pop = acc && !err && !PWRITE && PADDR == 8'd0;
    flush = wr && PADDR == 8'd3 && PWDATA[0];
    push = rx_valid && !flush && (!full || pop);
    drop = rx_valid && !flush && full && !pop;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d = drop || (ovf_q && !(wr && PADDR == 8'd1 && PWDATA[2]));
    irq_en_d = (wr && PADDR == 8'd3) ? PWDATA[1] : irq_en_q;
    thresh_d = (wr && PADDR == 8'd4) ? PWDATA : thresh_q;
    th_eff = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
    irq_d = irq_en_q && (CW'(count_q) >= CW'(th_eff) || ovf_q);
  end
  always_comb begin
    PRDATA = '0;
    if (acc && !err && !PWRITE)
      case (PADDR)
        8'd0:    PRDATA = 8'(mem[rd_ptr_q]);
        8'd1:    PRDATA = {5'b0, ovf_q, full, empty};
        8'd2:    PRDATA = 8'(count_q);
        8'd3:    PRDATA = {6'b0, irq_en_q, 1'b0};
        default: PRDATA = thresh_q;
      endcase
  end
  assign PREADY = 1'b1;
  assign PSLVERR = err;
  assign mem_state = {full, empty};
  assign overflow = ovf_q;
  assign rx_irq = irq_q;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= rx_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= 8'd1;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      irq_q <= irq_d;
    end
endmodule
